g11620_pix_capture: RTL

Pixel capture and line-accumulation stage directly downstream of the G11620 sensor controller. After each sensor `ad_sp` pulse it samples `PIX_NUM+1` consecutive ADC words and accumulates them per pixel into an internal line buffer across `cap_num_in` lines. When the session completes it streams the summed line out over a valid/ready interface to the host-side packer.

---
 rtl/g11620_pix_capture_pkg.sv | 21 ++
 rtl/g11620_pix_capture_pix_acc_ram.sv | 24 ++
 rtl/g11620_pix_capture.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/g11620_pix_capture_pkg.sv
// Shared constants for the G11620 pixel capture / line accumulation stage.
// Optional saturating accumulate: define G11620_PIX_SAT_EN.
package g11620_pix_capture_pkg;

    localparam int PIX_NUM_DEF = 511;
    localparam int ADC_W_DEF   = 16;
    localparam int ACC_W_DEF   = 32;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_SP = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_FLUSH   = 3'd3;
    localparam logic [2:0] ST_READOUT = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // A line count of zero still captures one line.
    function automatic logic [15:0] cap_fix(input logic [15:0] n);
        return (n == 16'd0) ? 16'd1 : n;
    endfunction

endpackage

// File: rtl/g11620_pix_capture_pix_acc_ram.sv
// Line accumulation buffer: simple dual-port RAM,
// one write port and one registered (1-cycle) read port.
module pix_acc_ram #(
    parameter int DEPTH = 512,
    parameter int W     = 32,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write and synchronous read; no read-during-write ordering needed.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/g11620_pix_capture.sv
// G11620 pixel capture: per-pixel multi-line accumulate, valid/ready readout.
// Optional saturating accumulate and sticky sat_o: define G11620_PIX_SAT_EN.
module g11620_pix_capture
    import g11620_pix_capture_pkg::*;
#(
    parameter int PIX_NUM = PIX_NUM_DEF,
    parameter int ADC_W   = ADC_W_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic             soft_reset_in,
    input  logic [15:0]      cap_num_in,
    input  logic             ad_sp,
    input  logic [ADC_W-1:0] adc_data_in,
    output logic [ACC_W-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_in,
    output logic             m_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             sat_o
);

    localparam int AW = (PIX_NUM > 0) ? $clog2(PIX_NUM + 1) : 1;
    localparam logic [AW-1:0] LAST = AW'(PIX_NUM);

    logic [2:0]       state;
    logic             start_d;
    logic [15:0]      cap_num;
    logic [15:0]      line_cnt;
    logic [AW-1:0]    pix_cnt;
    logic [1:0]       flush_cnt;

    logic             s0_vld;
    logic             s0_first;
    logic [AW-1:0]    s0_idx;
    logic [ADC_W-1:0] s0_data;

    logic [ACC_W-1:0] rdata;
    logic [ACC_W-1:0] wdata;
    logic [ACC_W-1:0] acc_old;
    logic [AW-1:0]    raddr;

    logic [AW-1:0]    rd_ptr;
    logic             rd_more;
    logic             rd_inflight;
    logic             rd_last;
    logic [ACC_W-1:0] f_data [2];
    logic [1:0]       f_last;
    logic             f_wp;
    logic             f_rp;
    logic [1:0]       f_cnt;

    logic             start_edge;
    logic             start_go;
    logic             push;
    logic             pop;
    logic             issue;
    logic [1:0]       occ;

    assign start_edge = start_in & ~start_d;
    assign start_go   = (state == ST_IDLE) & start_edge & ~soft_reset_in;
    assign push       = rd_inflight;
    assign pop        = m_valid_o & m_ready_in;
    assign occ        = f_cnt + {1'b0, rd_inflight};
    assign issue      = (state == ST_READOUT) & rd_more &
                        ((occ < 2'd2) | pop);
    assign raddr      = (state == ST_READOUT) ? rd_ptr : pix_cnt;

    assign m_valid_o = (state == ST_READOUT) & (f_cnt != 2'd0);
    assign m_last_o  = m_valid_o & f_last[f_rp];
    assign m_data_o  = f_data[f_rp];
    assign busy_o    = (state != ST_IDLE);
    assign done_o    = (state == ST_DONE);

    assign acc_old = s0_first ? {ACC_W{1'b0}} : rdata;

`ifdef G11620_PIX_SAT_EN
    logic [ACC_W:0] sum;
    logic           sat_q;

    // Widened add, clipped to all-ones on carry out.
    always_comb begin
        sum   = {1'b0, acc_old} + (ACC_W+1)'(s0_data);
        wdata = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

    // Sticky clip flag, cleared when a session starts.
    always_ff @(posedge clk) begin
        if (!rst_n)                 sat_q <= 1'b0;
        else if (start_go)          sat_q <= 1'b0;
        else if (s0_vld && sum[ACC_W]) sat_q <= 1'b1;
    end

    assign sat_o = sat_q;
`else
    logic [ACC_W-1:0] sum;

    // Wrapping add modulo 2^ACC_W.
    always_comb begin
        sum   = acc_old + ACC_W'(s0_data);
        wdata = sum;
    end

    assign sat_o = 1'b0;
`endif

    // Session control FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            start_d   <= 1'b0;
            cap_num   <= 16'd1;
            line_cnt  <= 16'd0;
            pix_cnt   <= '0;
            flush_cnt <= 2'd0;
        end else begin
            start_d <= start_in;
            if (soft_reset_in) begin
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start_edge) begin
                            cap_num  <= cap_fix(cap_num_in);
                            line_cnt <= 16'd0;
                            state    <= ST_WAIT_SP;
                        end
                    end
                    ST_WAIT_SP: begin
                        if (ad_sp) begin
                            pix_cnt <= '0;
                            state   <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == LAST) begin
                            if (line_cnt == cap_num - 16'd1) begin
                                flush_cnt <= 2'd0;
                                state     <= ST_FLUSH;
                            end else begin
                                line_cnt <= line_cnt + 16'd1;
                                state    <= ST_WAIT_SP;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        flush_cnt <= flush_cnt + 2'd1;
                        if (flush_cnt == 2'd1) state <= ST_READOUT;
                    end
                    ST_READOUT: begin
                        if (pop && m_last_o) state <= ST_DONE;
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Accumulate stage 0: register sample/index while the RAM read is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_vld   <= 1'b0;
            s0_first <= 1'b0;
            s0_idx   <= '0;
            s0_data  <= '0;
        end else begin
            s0_vld   <= (state == ST_CAPTURE) & ~soft_reset_in;
            s0_first <= (line_cnt == 16'd0);
            s0_idx   <= pix_cnt;
            s0_data  <= adc_data_in;
        end
    end

    // Readout: read issue and 2-entry skid buffer covering RAM latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            rd_more     <= 1'b0;
            rd_inflight <= 1'b0;
            rd_last     <= 1'b0;
            f_data[0]   <= '0;
            f_data[1]   <= '0;
            f_last      <= 2'b00;
            f_wp        <= 1'b0;
            f_rp        <= 1'b0;
            f_cnt       <= 2'd0;
        end else if (soft_reset_in) begin
            rd_more     <= 1'b0;
            rd_inflight <= 1'b0;
            f_wp        <= 1'b0;
            f_rp        <= 1'b0;
            f_cnt       <= 2'd0;
        end else begin
            if (state == ST_FLUSH) begin
                rd_ptr  <= '0;
                rd_more <= 1'b1;
            end
            rd_inflight <= issue;
            if (issue) begin
                rd_last <= (rd_ptr == LAST);
                rd_ptr  <= rd_ptr + 1'b1;
                if (rd_ptr == LAST) rd_more <= 1'b0;
            end
            if (push) begin
                f_data[f_wp] <= rdata;
                f_last[f_wp] <= rd_last;
                f_wp         <= ~f_wp;
            end
            if (pop) f_rp <= ~f_rp;
            f_cnt <= f_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    pix_acc_ram #(
        .DEPTH (PIX_NUM + 1),
        .W     (ACC_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (s0_vld),
        .waddr (s0_idx),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule
